// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the sequential ALU controller.
// State encoding and the unforced next-state rule live here.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  localparam logic [1:0] ST_S0 = 2'b00;
  localparam logic [1:0] ST_S1 = 2'b01;
  localparam logic [1:0] ST_S2 = 2'b10;
  localparam logic [1:0] ST_S3 = 2'b11;

  // Advance only on a qualified step with input_bit low.
  function automatic state_t next_unforced(
    input state_t cur,
    input logic   step,
    input logic   input_bit
  );
    state_t n;
    n = cur;
    if (step && !input_bit)
      n = state_t'(cur + 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/seq_alu_fsm_op.sv
// Combinational per-state ALU: OR, SUB/borrow,
// NOT-plus-constant/carry, XOR.
module seq_alu_op
  import seq_alu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ADD_CONST = 4
) (
  input  state_t           state,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic [WIDTH-1:0] result,
  output logic             cflag
);

  localparam logic [WIDTH-1:0] K = WIDTH'(ADD_CONST);

  logic [WIDTH:0] diff;
  logic [WIDTH:0] sum;

  // Extra top bit carries the borrow / carry-out.
  assign diff = {1'b0, RA} - {1'b0, RB};
  assign sum  = {1'b0, ~RA} + {1'b0, K};

  always_comb begin
    result = '0;
    cflag  = 1'b0;
    unique case (state)
      S0: result = RA | RB;
      S1: begin
        result = diff[WIDTH-1:0];
        cflag  = diff[WIDTH];
      end
      S2: begin
        result = sum[WIDTH-1:0];
        cflag  = sum[WIDTH];
      end
      S3: result = RA ^ RB;
      default: begin
        result = '0;
        cflag  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu_fsm.sv
// Four-state Moore controller with registered per-state ALU
// results and a dwell timeout that forces a return to S0.
module seq_alu_fsm
  import seq_alu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ADD_CONST = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             input_bit,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic [WIDTH-1:0] RA_out,
  output logic [WIDTH-1:0] RC,
  output logic             cflag,
  output logic             output_bit,
  output logic             timeout,
  output logic [1:0]       present_state,
  output logic [1:0]       next_state
);

  localparam int DW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DW-1:0] D_MAX  = DW'(TIMEOUT);
  localparam logic [DW-1:0] D_LAST =
    DW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           cur;
  state_t           nxt_free;
  logic             force_s0;
  logic [DW-1:0]    dwell;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  assign cur        = state_t'(present_state);
  assign output_bit = (present_state == ST_S1);

  // Timeout only overrides a hold; a real advance wins.
  always_comb begin
    nxt_free   = next_unforced(cur, step, input_bit);
    force_s0   = (TIMEOUT != 0) && (cur != S0)
               && (dwell == D_LAST) && (nxt_free == cur);
    next_state = force_s0 ? ST_S0 : nxt_free;
  end

  seq_alu_op #(
    .WIDTH     (WIDTH),
    .ADD_CONST (ADD_CONST)
  ) u_op (
    .state  (cur),
    .RA     (RA),
    .RB     (RB),
    .result (alu_res),
    .cflag  (alu_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      present_state <= ST_S0;
      dwell         <= '0;
      RA_out        <= '0;
      RC            <= '0;
      cflag         <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      present_state <= next_state;
      RA_out        <= ~RA;
      RC            <= alu_res;
      cflag         <= alu_c;
      timeout       <= force_s0;
      if (next_state != present_state)
        dwell <= '0;
      else if (dwell != D_MAX)
        dwell <= dwell + DW'(1);
    end
  end

endmodule

// File: tb/tb_seq_alu_fsm.sv
// Directed bench for seq_alu_fsm with an integer reference
// model checked every cycle plus literal expectations.
module tb_seq_alu_fsm;

  localparam int W  = 4;
  localparam int AC = 4;
  localparam int T  = 8;

  logic       clk;
  logic       reset;
  logic       step;
  logic       input_bit;
  logic [3:0] RA;
  logic [3:0] RB;
  logic [3:0] RA_out;
  logic [3:0] RC;
  logic       cflag;
  logic       output_bit;
  logic       timeout;
  logic [1:0] present_state;
  logic [1:0] next_state;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  int ms, md, mrc, mcf, mra, mto;

  seq_alu_fsm #(
    .WIDTH     (W),
    .ADD_CONST (AC),
    .TIMEOUT   (T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .step          (step),
    .input_bit     (input_bit),
    .RA            (RA),
    .RB            (RB),
    .RA_out        (RA_out),
    .RC            (RC),
    .cflag         (cflag),
    .output_bit    (output_bit),
    .timeout       (timeout),
    .present_state (present_state),
    .next_state    (next_state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int m_next(input int s, input int d,
                                input bit st, input bit ib,
                                output bit frc);
    int n;
    n   = (st && !ib) ? (s + 1) % 4 : s;
    frc = (T != 0) && (s != 0) && (d == T - 1) && (n == s);
    return frc ? 0 : n;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit f;
    int n, a, b, s2;
    if (reset) begin
      ms = 0; md = 0; mrc = 0; mcf = 0; mra = 0; mto = 0;
    end else begin
      a  = int'(RA);
      b  = int'(RB);
      n  = m_next(ms, md, step, input_bit, f);
      s2 = (15 - a) + AC;
      case (ms)
        0: begin mrc = a | b; mcf = 0; end
        1: begin mrc = (a - b + 16) % 16; mcf = (a < b); end
        2: begin mrc = s2 % 16; mcf = (s2 >= 16); end
        default: begin mrc = a ^ b; mcf = 0; end
      endcase
      mra = 15 - a;
      mto = f;
      if (n != ms) md = 0;
      else if (md < T) md++;
      ms = n;
    end
  end

  always @(negedge clk) begin
    bit f;
    int n;
    if (chk_en) begin
      n = m_next(ms, md, step, input_bit, f);
      chk("m_state", present_state, ms);
      chk("m_next", next_state, n);
      chk("m_obit", output_bit, (ms == 1));
      chk("m_rc", RC, mrc);
      chk("m_cflag", cflag, mcf);
      chk("m_raout", RA_out, mra);
      chk("m_timeout", timeout, mto);
    end
  end

  task automatic cyc(input logic s, input logic ib,
                     input logic [3:0] a, input logic [3:0] b);
    step      = s;
    input_bit = ib;
    RA        = a;
    RB        = b;
    @(posedge clk);
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; step = 0; input_bit = 0; RA = 0; RB = 0;
    #1 reset = 1;
    chk_en = 1;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_state", present_state, 2'b00);
    chk("rst_rc", RC, 4'h0);
    chk("rst_raout", RA_out, 4'h0);
    chk("rst_obit", output_bit, 1'b0);
    chk("rst_next", next_state, 2'b00);
    reset = 0;

    cyc(0, 0, 4'b1010, 4'b0101);
    chk("s0_hold_nostep", present_state, 2'b00);
    chk("s0_or", RC, 4'b1111);
    chk("s0_cflag", cflag, 1'b0);

    cyc(1, 0, 4'b0010, 4'b0101);
    chk("adv_s1", present_state, 2'b01);
    chk("obit_s1", output_bit, 1'b1);

    cyc(1, 1, 4'b0010, 4'b0101);
    chk("s1_hold", present_state, 2'b01);
    chk("s1_sub_borrow", RC, 4'b1101);
    chk("s1_borrow", cflag, 1'b1);

    cyc(1, 0, 4'b0101, 4'b0010);
    chk("adv_s2", present_state, 2'b10);
    chk("obit_s2", output_bit, 1'b0);
    chk("s1_sub", RC, 4'b0011);
    chk("s1_noborrow", cflag, 1'b0);

    cyc(1, 1, 4'b0011, 4'b0000);
    chk("s2_addc", RC, 4'b0000);
    chk("s2_carry", cflag, 1'b1);
    chk("raout", RA_out, 4'b1100);
    for (int i = 2; i <= 7; i++) begin
      cyc(1, 1, 4'b0011, 4'b0000);
      chk("s2_dwell_state", present_state, 2'b10);
      chk("s2_dwell_to", timeout, 1'b0);
    end
    cyc(1, 1, 4'b0011, 4'b0000);
    chk("forced_s0", present_state, 2'b00);
    chk("timeout_pulse", timeout, 1'b1);

    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 4'h3, 4'h9);
      chk("s0_no_timeout", timeout, 1'b0);
      chk("s0_stays", present_state, 2'b00);
    end

    cyc(1, 0, 4'h0, 4'h0);
    cyc(1, 0, 4'h0, 4'h0);
    cyc(1, 0, 4'h0, 4'h0);
    chk("adv_s3", present_state, 2'b11);
    cyc(1, 1, 4'b1100, 4'b1010);
    chk("s3_xor", RC, 4'b0110);
    chk("s3_hold", present_state, 2'b11);

    #1;
    reset     = 1;
    step      = 0;
    input_bit = 0;
    #1;
    chk("async_state", present_state, 2'b00);
    chk("async_rc", RC, 4'h0);
    chk("async_cflag", cflag, 1'b0);
    chk("async_timeout", timeout, 1'b0);
    #7 reset = 0;

    cyc(0, 0, 4'h1, 4'h2);
    chk("post_rst_nostep", present_state, 2'b00);
    chk("post_rst_rc", RC, 4'h3);

    cyc(1, 0, 4'h1, 4'h2);
    chk("post_rst_adv", present_state, 2'b01);
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 1, 4'h7, 4'h1);
      chk("s1_dwell_state", present_state, 2'b01);
    end
    cyc(1, 0, 4'h7, 4'h1);
    chk("adv_beats_to", present_state, 2'b10);
    chk("adv_no_to", timeout, 1'b0);
    cyc(0, 0, 4'h0, 4'h0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu_fsm.md
# seq_alu_fsm

Parametrised four-state Moore controller with a per-state ALU datapath. A serial control bit steps the FSM through S0→S1→S2→S3→S0, and each state selects the operation applied to the two operand buses. Compared with the fixed 4-bit block it replaces, it adds operand width and constant as parameters, a step-qualifier strobe, registered results with a carry/borrow flag, and a per-state dwell timeout. It sits between operand registers and the result bus in the lab datapath.

## Interface
- `WIDTH`, 4, operand/result width in bits (≥2)
- `ADD_CONST`, 4, constant added in S2, truncated to `WIDTH` bits
- `TIMEOUT`, 8, cycles a non-S0 state may hold before forced return to S0; 0 disables the timeout
- `clk`  in  1  single clock, all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high; forces all registers to their reset values immediately
- `step`  in  1  qualifier; FSM evaluates `input_bit` only when `step`=1
- `input_bit`  in  1  control bit; 1 = hold state, 0 = advance
- `RA`  in  WIDTH  operand A
- `RB`  in  WIDTH  operand B
- `RA_out`  out  WIDTH  registered ~RA
- `RC`  out  WIDTH  registered ALU result
- `cflag`  out  1  registered carry (S2) or borrow (S1); 0 in S0/S3
- `output_bit`  out  1  Moore output, 1 iff present_state = S1
- `timeout`  out  1  one-cycle pulse on forced return to S0
- `present_state`  out  2  state register
- `next_state`  out  2  combinational next state

## Operation
- State encodings: S0=00, S1=01, S2=10, S3=11.
- Next state: if `step`=0, next = present. If `step`=1 and `input_bit`=1, next = present. If `step`=1 and `input_bit`=0, next = present+1 mod 4.
- Timeout override:
  - `dwell` counter, width clog2(TIMEOUT+1), cleared on every state change and incremented each cycle the state holds.
  - Applies when TIMEOUT≠0, present≠S0, `dwell`=TIMEOUT−1 and the unforced next = present.
  - Then next = S0 and `timeout`=1 on the following cycle.
  - S0 never times out; its `dwell` saturates at TIMEOUT.
- ALU, selected by present_state and evaluated on the current `RA`/`RB`, all arithmetic mod 2^WIDTH:
  - S0: RA | RB (bitwise), cflag=0
  - S1: RA − RB, cflag = borrow (RA < RB unsigned)
  - S2: ~RA + ADD_CONST, cflag = carry out of bit WIDTH−1
  - S3: RA ^ RB, cflag=0
- `output_bit` is decoded directly from the state register, with no added latency.

## Timing
- Reset values: present_state=S0, dwell=0, RA_out=0, RC=0, cflag=0, timeout=0. Hence output_bit=0 and next_state=S0 until the first step with input_bit=0.
- At rising edge k:
  - present_state ← next_state.
  - RC/cflag ← ALU(present_state before edge k, RA/RB sampled at edge k).
  - RA_out ← ~RA.
  - RC therefore lags the state it reflects by one cycle.
- `timeout` is high for exactly the cycle following the forced transition edge.
- Reset asserted mid-operation:
  - All outputs go to reset values asynchronously.
  - The first edge after deassertion behaves as from S0 with dwell=0.
- A step that advances on the same cycle the timeout condition is met: the advance takes priority and no timeout is raised.

## Structure
- Package `seq_alu_pkg`:
  - `state_t` 2-bit enum (S0..S3)
  - encoding constants
  - function returning the unforced next state
- Sub-module `seq_alu_op`: purely combinational; inputs state, RA, RB; outputs WIDTH-bit result and cflag. The top level owns FSM, dwell counter and output registers.

## Test plan
All scenarios use WIDTH=4, ADD_CONST=4, TIMEOUT=8.

- Reset, then step=1 with input_bit=0 for four cycles → present_state 00→01→10→11→00; output_bit high only in the S1 cycle.
- In S0: RA=1010, RB=0101 → RC=1111, cflag=0. In S3: RA=1100, RB=1010 → RC=0110.
- In S1: RA=0010, RB=0101 → RC=1101, cflag=1. Then RA=0101, RB=0010 → RC=0011, cflag=0.
- In S2: RA=0011 → RC=0000, cflag=1. RA_out=1100 one cycle after RA is applied.
- Hold S2 with step=1, input_bit=1 for 8 cycles → forced to S0 on the 8th edge; timeout pulses 1 cycle. Holding S0 for 20 cycles → no timeout.
- Assert reset between edges while in S3 with RC≠0 → immediately present_state=00, RC=0, cflag=0. step=0 with input_bit=0 → no state change.
